// File: rtl/layer_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : layer_ctrl_fsm
// Description : Layer sequencer for the CNN datapath; drives the layer state
//               decoded by the feature-map counter.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module layer_ctrl_fsm #(
  parameter int unsigned PAD_CYCLES = 14884,
  parameter int unsigned CONV_FMAPS = 24,
  parameter int unsigned UP_FMAPS   = 96,
  parameter int unsigned NUM_RES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] fmap_idx_delay4,
  output logic [3:0] state,
  output logic       layer_start,
  output logic [15:0] pad_count,
  output logic [2:0] res_iter,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PADDING = 4'd1,
    S_CONV1   = 4'd2,
    S_RES_1   = 4'd3,
    S_RES_2   = 4'd4,
    S_UP_1    = 4'd5,
    S_UP_2    = 4'd6,
    S_CONV2   = 4'd7,
    S_FINISH  = 4'd8
  } state_t;

  localparam logic [6:0]  C_CONV_IDX = 7'(CONV_FMAPS);
  localparam logic [6:0]  C_UP_IDX   = 7'(UP_FMAPS);
  localparam logic [15:0] C_PAD_LAST = 16'(PAD_CYCLES - 1);
  localparam logic [2:0]  C_RES_LAST = 3'(NUM_RES - 1);

  state_t      r_state;
  logic        r_layer_start;
  logic [15:0] r_pad_count;
  logic [2:0]  r_res_iter;
  logic        w_match_conv;
  logic        w_match_up;

  // r_layer_start doubles as the entry flag: a stale index seen in the
  // first cycle of a layer must not advance it.
  assign w_match_conv = !r_layer_start && (fmap_idx_delay4 != 7'h7f) &&
                        (fmap_idx_delay4 == C_CONV_IDX);
  assign w_match_up   = !r_layer_start && (fmap_idx_delay4 != 7'h7f) &&
                        (fmap_idx_delay4 == C_UP_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      r_state       <= S_IDLE;
      r_layer_start <= 1'b0;
      r_pad_count   <= 16'd0;
      r_res_iter    <= 3'd0;
    end else begin
      r_layer_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_PADDING;
            r_pad_count <= 16'd0;
            r_res_iter  <= 3'd0;
          end
        end
        S_PADDING: begin
          if (r_pad_count == C_PAD_LAST) begin
            r_state       <= S_CONV1;
            r_pad_count   <= 16'd0;
            r_layer_start <= 1'b1;
          end else begin
            r_pad_count <= r_pad_count + 16'd1;
          end
        end
        S_CONV1: begin
          if (w_match_conv) begin
            r_state       <= S_RES_1;
            r_layer_start <= 1'b1;
          end
        end
        S_RES_1: begin
          if (w_match_conv) begin
            r_state       <= S_RES_2;
            r_layer_start <= 1'b1;
          end
        end
        S_RES_2: begin
          if (w_match_conv) begin
            r_layer_start <= 1'b1;
            if (r_res_iter < C_RES_LAST) begin
              r_state    <= S_RES_1;
              r_res_iter <= r_res_iter + 3'd1;
            end else begin
              r_state <= S_UP_1;
            end
          end
        end
        S_UP_1: begin
          if (w_match_up) begin
            r_state       <= S_UP_2;
            r_layer_start <= 1'b1;
          end
        end
        S_UP_2: begin
          if (w_match_up) begin
            r_state       <= S_CONV2;
            r_layer_start <= 1'b1;
          end
        end
        S_CONV2: begin
          if (w_match_conv) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_pad_count <= 16'd0;
        end
      endcase
    end
  end

  assign state       = r_state;
  assign layer_start = r_layer_start;
  assign pad_count   = r_pad_count;
  assign res_iter    = r_res_iter;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_layer_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_layer_ctrl_fsm
// Description : Directed plus random bench for layer_ctrl_fsm against a
//               table-driven layer-program model.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_layer_ctrl_fsm;

  localparam int PAD = 14884;
  localparam int NRES = 4;
  localparam int NLAY = 1 + 2 * NRES + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  fmap_idx_delay4 = 7'd0;
  logic [3:0]  state;
  logic        layer_start;
  logic [15:0] pad_count;
  logic [2:0]  res_iter;
  logic        busy;
  logic        done;

  int n_pass = 0;
  int n_chk  = 0;

  // Image program: one entry per compute layer in execution order.
  int lay_state[NLAY];
  int lay_term[NLAY];
  int lay_res[NLAY];

  // Model: mode 0 idle, 1 padding, 2 in layer lay_*[m_pos], 3 finish.
  int m_mode = 0;
  int m_pos = 0;
  int m_pad = 0;
  int m_res = 0;
  int m_first = 0;

  int exp_seq[8] = '{4, 3, 4, 3, 4, 3, 4, 5};
  int exp_res[8] = '{0, 1, 1, 2, 2, 3, 3, 3};

  layer_ctrl_fsm dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .fmap_idx_delay4 (fmap_idx_delay4),
    .state           (state),
    .layer_start     (layer_start),
    .pad_count       (pad_count),
    .res_iter        (res_iter),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic int exp_state();
    case (m_mode)
      0: return 0;
      1: return 1;
      2: return lay_state[m_pos];
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_step();
    int first_prev;
    if (!rst_n || abort) begin
      m_mode = 0; m_pad = 0; m_res = 0; m_first = 0;
      return;
    end
    first_prev = m_first;
    m_first = 0;
    case (m_mode)
      0: if (start) begin m_mode = 1; m_pad = 0; m_res = 0; end
      1: begin
        if (m_pad == PAD - 1) begin
          m_mode = 2; m_pos = 0; m_pad = 0; m_first = 1; m_res = lay_res[0];
        end else m_pad++;
      end
      2: begin
        if (first_prev == 0 && int'(fmap_idx_delay4) == lay_term[m_pos]) begin
          if (m_pos == NLAY - 1) m_mode = 3;
          else begin
            m_pos++; m_first = 1; m_res = lay_res[m_pos];
          end
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), 32'(exp_state()));
    chk("layer_start", 32'(layer_start), 32'(m_first));
    chk("pad_count", 32'(pad_count), 32'(m_pad));
    chk("res_iter", 32'(res_iter), 32'(m_res));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("done", 32'(done), 32'(m_mode == 3));
  endtask

  task automatic advance_to(input int target);
    int budget;
    budget = 20000;
    while (exp_state() != target && budget > 0) begin
      if (m_mode == 2 && m_first == 0) fmap_idx_delay4 = 7'(lay_term[m_pos]);
      else fmap_idx_delay4 = 7'd0;
      tick();
      budget--;
    end
    fmap_idx_delay4 = 7'd0;
    if (budget == 0) chk("advance_timeout", 32'(state), 32'(target));
  endtask

  initial begin
    int cnt;
    int guard;
    int r;
    lay_state[0] = 2; lay_term[0] = 24; lay_res[0] = 0;
    for (int i = 0; i < NRES; i++) begin
      lay_state[1 + 2 * i] = 3; lay_term[1 + 2 * i] = 24; lay_res[1 + 2 * i] = i;
      lay_state[2 + 2 * i] = 4; lay_term[2 + 2 * i] = 24; lay_res[2 + 2 * i] = i;
    end
    lay_state[NLAY - 3] = 5; lay_term[NLAY - 3] = 96; lay_res[NLAY - 3] = NRES - 1;
    lay_state[NLAY - 2] = 6; lay_term[NLAY - 2] = 96; lay_res[NLAY - 2] = NRES - 1;
    lay_state[NLAY - 1] = 7; lay_term[NLAY - 1] = 24; lay_res[NLAY - 1] = NRES - 1;

    // Reset
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Padding length
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0; guard = 0;
    while (state == 4'd1 && guard < 20000) begin
      cnt++; guard++;
      tick();
    end
    chk("pad_cycles", 32'(cnt), 32'(PAD));
    chk("conv1_entry_state", 32'(state), 32'd2);
    chk("conv1_entry_ls", 32'(layer_start), 32'd1);

    // Blanking across CONV1 -> RES_1
    fmap_idx_delay4 = 7'd24;
    tick(); chk("blank_conv1", 32'(state), 32'd2);
    tick(); chk("blank_res1_enter", 32'(state), 32'd3);
    tick(); chk("blank_res1_hold", 32'(state), 32'd3);
    fmap_idx_delay4 = 7'd0;
    tick();

    // Residual loop
    for (int k = 0; k < 8; k++) begin
      fmap_idx_delay4 = 7'd24;
      tick();
      chk("resloop_state", 32'(state), 32'(exp_seq[k]));
      chk("resloop_iter", 32'(res_iter), 32'(exp_res[k]));
      chk("resloop_ls", 32'(layer_start), 32'd1);
      fmap_idx_delay4 = 7'd0;
      tick();
    end

    // Upsample and final layer
    fmap_idx_delay4 = 7'd24; tick(); chk("up1_wrong_idx", 32'(state), 32'd5);
    fmap_idx_delay4 = 7'd96; tick(); chk("up1_to_up2", 32'(state), 32'd6);
    fmap_idx_delay4 = 7'd0;  tick();
    fmap_idx_delay4 = 7'd96; tick(); chk("up2_to_conv2", 32'(state), 32'd7);
    fmap_idx_delay4 = 7'd0;  tick();
    fmap_idx_delay4 = 7'd24; tick();
    chk("finish_state", 32'(state), 32'd8);
    chk("finish_done", 32'(done), 32'd1);
    fmap_idx_delay4 = 7'd0;  tick();
    chk("finish_to_idle", 32'(state), 32'd0);
    chk("done_clear", 32'(done), 32'd0);

    // Start ignored in RES_2, abort in UP_2, start+abort in IDLE
    start = 1'b1; tick(); start = 1'b0;
    advance_to(4);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ignored", 32'(state), 32'd4);
    advance_to(6);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_up2", 32'(state), 32'd0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(state), 32'd0);

    // Reset mid-CONV2
    start = 1'b1; tick(); start = 1'b0;
    advance_to(7);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_conv2_state", 32'(state), 32'd0);
    chk("rst_conv2_busy", 32'(busy), 32'd0);
    chk("rst_conv2_res", 32'(res_iter), 32'd0);
    chk("rst_conv2_pad", 32'(pad_count), 32'd0);

    // Random phase
    for (int i = 0; i < 20000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = (m_mode != 1) && ($urandom_range(0, 299) == 0);
      rst_n = !((m_mode != 1) && ($urandom_range(0, 999) == 0));
      r = $urandom_range(0, 9);
      if (r < 3) fmap_idx_delay4 = 7'd24;
      else if (r < 6) fmap_idx_delay4 = 7'd96;
      else if (r == 6) fmap_idx_delay4 = 7'd127;
      else fmap_idx_delay4 = 7'($urandom_range(0, 127));
      tick();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; fmap_idx_delay4 = 7'd0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
